// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates the shared memory port between IF and MEM,
// and derives per-register stall/flush strobes plus a stall-cycle counter.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  input  logic             mem_req,
  input  logic [31:0]      mem_addr,
  input  logic             mem_wr,
  input  logic             port_done,
  output logic             port_req,
  output logic [31:0]      port_addr,
  output logic             port_wr,
  output logic             port_owner,
  output logic             if_done,
  output logic             mem_done,
  input  logic             id_hz,
  input  logic             br_e,
  input  logic [31:0]      br_pc,
  output logic             pc_re,
  output logic [31:0]      pc_rt,
  output logic [4:0]       stl,
  output logic [1:0]       flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_e;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic        owner;
  } port_t;

  localparam logic [4:0] STL_MEM  = 5'b01111;
  localparam logic [4:0] STL_LU   = 5'b00011;
  localparam logic [4:0] STL_PC   = 5'b00001;
  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_MEM  = 1'b1;

  state_e            state_q, state_d;
  port_t             port_q, port_d;
  logic              pend_q, pend_d;
  logic [31:0]       pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              mem_wait, if_busy;
  logic [31:0]       redir_tgt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      port_q    <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  // Arbiter: MEM wins in IDLE; a grant is registered so port_req rises next cycle.
  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    if_done  = 1'b0;
    mem_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d      = MEM_BUSY;
          port_d.req   = 1'b1;
          port_d.addr  = mem_addr;
          port_d.wr    = mem_wr;
          port_d.owner = OWN_MEM;
        end else if (if_req) begin
          state_d      = IF_BUSY;
          port_d.req   = 1'b1;
          port_d.addr  = if_addr;
          port_d.wr    = 1'b0;
          port_d.owner = OWN_IF;
        end
      end
      IF_BUSY: begin
        if (port_done) begin
          if_done    = 1'b1;
          state_d    = IDLE;
          port_d.req = 1'b0;
        end
      end
      MEM_BUSY: begin
        if (port_done) begin
          mem_done   = 1'b1;
          state_d    = IDLE;
          port_d.req = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_wait  = mem_req && !mem_done;
  assign if_busy   = (state_q == IF_BUSY);
  // A fresh branch in the same cycle overrides any older pending target.
  assign redir_tgt = br_e ? br_pc : pend_pc_q;

  always_comb begin
    stl       = '0;
    flush     = '0;
    pc_re     = 1'b0;
    pc_rt     = '0;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (!rst) begin
      flush = 2'b11;
    end else if (mem_wait) begin
      stl = STL_MEM;
    end else if (id_hz) begin
      stl   = STL_LU;
      flush = 2'b10;
    end else if (pend_q || (br_e && if_busy)) begin
      // Issue once the fetch drains; a pending target left over after the
      // fetch ended under a higher-priority stall issues at the first chance.
      if (if_done || !if_busy) begin
        pc_re  = 1'b1;
        pc_rt  = redir_tgt;
        flush  = 2'b01;
        pend_d = 1'b0;
      end else begin
        stl       = STL_PC;
        flush     = 2'b01;
        pend_d    = 1'b1;
        pend_pc_d = redir_tgt;
      end
    end else if (br_e) begin
      pc_re = 1'b1;
      pc_rt = br_pc;
      flush = 2'b01;
    end else if (if_req && !if_done) begin
      stl   = STL_PC;
      flush = 2'b01;
    end
  end

  assign cnt_d = (stl != '0) ? cnt_q + CNT_W'(1) : cnt_q;

  assign port_req   = port_q.req;
  assign port_addr  = port_q.addr;
  assign port_wr    = port_q.wr;
  assign port_owner = port_q.owner;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_wr = 1'b0, port_done = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, br_pc = '0;
  logic        id_hz = 1'b0, br_e = 1'b0;
  logic        port_req, port_wr, port_owner, if_done, mem_done, pc_re;
  logic [31:0] port_addr, pc_rt, stall_cnt;
  logic [4:0]  stl;
  logic [1:0]  flush;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .port_done(port_done),
    .port_req(port_req), .port_addr(port_addr), .port_wr(port_wr),
    .port_owner(port_owner), .if_done(if_done), .mem_done(mem_done),
    .id_hz(id_hz), .br_e(br_e), .br_pc(br_pc),
    .pc_re(pc_re), .pc_rt(pc_rt), .stl(stl), .flush(flush),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference model: the transaction currently owning the port, the pending
  // redirect, and the stall counter.
  logic        m_busy, m_own, m_wr, m_pend;
  logic [31:0] m_addr, m_ppc, m_cnt;
  // Per-cycle predictions
  logic        e_ifd, e_memd, e_re, n_pend;
  logic [4:0]  e_stl;
  logic [1:0]  e_fl;
  logic [31:0] e_rt, n_ppc;
  logic        got_ifd = 1'b0, got_memd = 1'b0;

  task automatic model_clear();
    m_busy = 0; m_own = 0; m_wr = 0; m_pend = 0;
    m_addr = '0; m_ppc = '0; m_cnt = '0;
  endtask

  // Predict and compare everything visible in the current cycle.
  task automatic eval();
    logic        fetch_busy;
    logic [31:0] tgt;
    #1;
    if (!rst) model_clear();
    fetch_busy = m_busy && !m_own;
    e_ifd  = rst && fetch_busy && port_done;
    e_memd = rst && m_busy && m_own && port_done;
    e_stl = '0; e_fl = '0; e_re = 0; e_rt = '0;
    n_pend = m_pend; n_ppc = m_ppc;
    if (!rst) begin
      e_fl = 2'b11;
    end else if (mem_req && !e_memd) begin
      e_stl = 5'b01111;
    end else if (id_hz) begin
      e_stl = 5'b00011; e_fl = 2'b10;
    end else if (br_e && !fetch_busy && !m_pend) begin
      e_re = 1; e_rt = br_pc; e_fl = 2'b01;
    end else if (br_e || m_pend) begin
      tgt = br_e ? br_pc : m_ppc;
      if (fetch_busy && !e_ifd) begin
        e_stl = 5'b00001; e_fl = 2'b01; n_pend = 1; n_ppc = tgt;
      end else begin
        e_re = 1; e_rt = tgt; e_fl = 2'b01; n_pend = 0;
      end
    end else if (if_req && !e_ifd) begin
      e_stl = 5'b00001; e_fl = 2'b01;
    end
    chk("port_req", port_req, m_busy);
    if (m_busy) begin
      chk("port_addr", port_addr, m_addr);
      chk("port_wr", port_wr, m_wr);
      chk("port_owner", port_owner, m_own);
    end
    chk("if_done", if_done, e_ifd);
    chk("mem_done", mem_done, e_memd);
    chk("stl", stl, e_stl);
    chk("flush", flush, e_fl);
    chk("pc_re", pc_re, e_re);
    chk("pc_rt", pc_rt, e_rt);
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  // Advance the model across the rising edge, then return to the falling edge.
  task automatic step();
    @(posedge clk);
    got_ifd = e_ifd;
    got_memd = e_memd;
    if (!rst) begin
      model_clear();
    end else begin
      if (e_stl != 0) m_cnt = m_cnt + 1;
      m_pend = n_pend;
      m_ppc  = n_ppc;
      if (m_busy) begin
        if (port_done) m_busy = 0;
      end else if (mem_req) begin
        m_busy = 1; m_own = 1; m_addr = mem_addr; m_wr = mem_wr;
      end else if (if_req) begin
        m_busy = 1; m_own = 0; m_addr = if_addr; m_wr = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] c0;
    model_clear();
    @(negedge clk);
    eval(); step();
    rst = 1;
    eval(); step();

    // Reset in the middle of a fetch
    if_req = 1; if_addr = 32'h40;
    eval(); step();
    eval(); chk("busy_before_rst", port_req, 1); step();
    rst = 0;
    eval(); chk("rst_port_req", port_req, 0); step();
    if_req = 0; rst = 1; port_done = 1;
    eval(); chk("stray_if_done", if_done, 0); chk("rst_cnt", stall_cnt, 0); step();
    port_done = 0;

    // Contention: MEM wins, IF granted afterwards
    if_req = 1; if_addr = 32'h80; mem_req = 1; mem_addr = 32'h100; mem_wr = 1;
    eval(); chk("cont_stl_grant", stl, 5'b01111); step();
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("cont_owner", port_owner, 1);
      chk("cont_addr", port_addr, 32'h100);
      chk("cont_wr", port_wr, 1);
      chk("cont_stl", stl, 5'b01111);
      step();
    end
    port_done = 1;
    eval(); chk("cont_mem_done", mem_done, 1); step();
    mem_req = 0; mem_wr = 0; port_done = 0;
    eval(); step();
    eval(); chk("cont_if_owner", port_owner, 0); chk("cont_if_addr", port_addr, 32'h80); step();
    port_done = 1;
    eval(); step();
    port_done = 0; if_req = 0;

    // Load-use hazard
    id_hz = 1;
    eval(); chk("lu_stl", stl, 5'b00011); chk("lu_flush", flush, 2'b10); c0 = stall_cnt; step();
    id_hz = 0;
    eval(); chk("lu_cnt", stall_cnt, c0 + 1); step();

    // Redirect with the port idle
    br_e = 1; br_pc = 32'h200;
    eval();
    chk("rd_re", pc_re, 1); chk("rd_rt", pc_rt, 32'h200);
    chk("rd_flush", flush, 2'b01); chk("rd_stl", stl, 0);
    step();
    br_e = 0;

    // Redirect arriving during a fetch, second one overwrites
    if_req = 1; if_addr = 32'h400;
    eval(); step();
    br_e = 1; br_pc = 32'h300;
    eval(); chk("rf_stl0", stl[0], 1); chk("rf_fl0", flush[0], 1); chk("rf_re0", pc_re, 0); step();
    br_pc = 32'h340;
    eval(); step();
    br_e = 0;
    eval(); chk("rf_hold", stl[0], 1); step();
    port_done = 1;
    eval();
    chk("rf_re", pc_re, 1); chk("rf_rt", pc_rt, 32'h340);
    chk("rf_ifd", if_done, 1); chk("rf_fl", flush[0], 1);
    step();
    port_done = 0; if_req = 0;

    // MEM wait masks a branch; nothing is left pending
    mem_req = 1; mem_addr = 32'h500; br_e = 1; br_pc = 32'h600;
    eval(); chk("ms_re", pc_re, 0); chk("ms_stl", stl, 5'b01111); step();
    eval(); chk("ms_re2", pc_re, 0); step();
    br_e = 0; port_done = 1;
    eval(); step();
    mem_req = 0; port_done = 0;
    eval(); chk("ms_nopend", pc_re, 0); step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (got_ifd) if_req = 0;
      if (got_memd) mem_req = 0;
      if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!mem_req && !m_pend && $urandom_range(3) == 0) begin
        mem_req = 1; mem_addr = $urandom; mem_wr = $urandom_range(1);
      end
      port_done = m_busy ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      id_hz = !m_pend && ($urandom_range(7) == 0);
      br_e = ($urandom_range(4) == 0);
      br_pc = $urandom & 32'hFFFF_FFFE;
      rst = ($urandom_range(199) != 0);
      if (!rst) begin if_req = 0; mem_req = 0; end
      eval(); step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
